// File: rtl/bcd_count_stage_pkg.sv
// Shared BCD constants for the seven-segment path (counter and digit decoder).
package bcd_count_stage_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  // One count step per second on the 50 MHz board clock.
  localparam int unsigned TICK_DIV_DEFAULT = 50000000;

  // Saturate a raw nibble to a legal BCD digit.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] x);
    return (x > BCD_MAX) ? BCD_MAX : x;
  endfunction

endpackage

// File: rtl/bcd_count_stage_rate_divider.sv
// Rate divider: emits a step strobe once every TICK_DIV enabled cycles.
module rate_divider
  import bcd_count_stage_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
  parameter int unsigned DIV_W    = 26
) (
  input  logic CLOCK_50,
  input  logic Resetn,
  input  logic En,
  input  logic Clr,
  output logic step
);

  localparam logic [DIV_W-1:0] RELOAD = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  assign step = En & (div_q == '0);

  // Reload on clear, pause or step so every run waits a full period.
  always_comb begin
    div_d = div_q - DIV_W'(1);
    if (Clr || !En || step) begin
      div_d = RELOAD;
    end
  end

  // Divider register.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      div_q <= RELOAD;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/bcd_count_stage.sv
// Two-digit BCD up/down counter with load, enable and Tick/Wrap pulses.
module bcd_count_stage
  import bcd_count_stage_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
  parameter int unsigned DIV_W    = 26
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic       En,
  input  logic       Up,
  input  logic       Load,
  input  logic [7:0] LoadVal,
  output logic [3:0] Tens,
  output logic [3:0] Ones,
  output logic       Tick,
  output logic       Wrap
);

  logic             step;
  logic [BCD_W-1:0] tens_q, tens_d;
  logic [BCD_W-1:0] ones_q, ones_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;

  rate_divider #(
    .TICK_DIV (TICK_DIV),
    .DIV_W    (DIV_W)
  ) u_div (
    .CLOCK_50 (CLOCK_50),
    .Resetn   (Resetn),
    .En       (En),
    .Clr      (Load),
    .step     (step)
  );

  // Next digits: load wins over a coincident step; otherwise step with carry/borrow.
  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    if (Load) begin
      tens_d = bcd_clamp(LoadVal[7:4]);
      ones_d = bcd_clamp(LoadVal[3:0]);
    end else if (step) begin
      tick_d = 1'b1;
      if (Up) begin
        if (ones_q < BCD_MAX) begin
          ones_d = ones_q + 4'd1;
        end else begin
          ones_d = '0;
          if (tens_q < BCD_MAX) begin
            tens_d = tens_q + 4'd1;
          end else begin
            tens_d = '0;
            wrap_d = 1'b1;
          end
        end
      end else begin
        if (ones_q != '0) begin
          ones_d = ones_q - 4'd1;
        end else begin
          ones_d = BCD_MAX;
          if (tens_q != '0) begin
            tens_d = tens_q - 4'd1;
          end else begin
            tens_d = BCD_MAX;
            wrap_d = 1'b1;
          end
        end
      end
    end
  end

  // Digit and pulse registers.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      tens_q <= '0;
      ones_q <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  assign Tens = tens_q;
  assign Ones = ones_q;
  assign Tick = tick_q;
  assign Wrap = wrap_q;

endmodule

// File: tb/tb_bcd_count_stage.sv
// Randomised and directed bench for bcd_count_stage with TICK_DIV = 4.
module tb_bcd_count_stage;

  localparam int TDIV = 4;

  logic       CLOCK_50 = 1'b0;
  logic       Resetn   = 1'b1;
  logic       En       = 1'b0;
  logic       Up       = 1'b1;
  logic       Load     = 1'b0;
  logic [7:0] LoadVal  = 8'h00;
  logic [3:0] Tens, Ones;
  logic       Tick, Wrap;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: value as an integer 0..99 and the number of
  // consecutive enabled edges since the last restart of the rate period.
  int mval = 0;
  int mrun = 0;
  bit mtick = 0;
  bit mwrap = 0;

  bcd_count_stage #(
    .TICK_DIV (TDIV),
    .DIV_W    (3)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .Resetn   (Resetn),
    .En       (En),
    .Up       (Up),
    .Load     (Load),
    .LoadVal  (LoadVal),
    .Tens     (Tens),
    .Ones     (Ones),
    .Tick     (Tick),
    .Wrap     (Wrap)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic int clampd(input int x);
    return (x > 9) ? 9 : x;
  endfunction

  function automatic logic [9:0] exp_vec();
    logic [3:0] t, o;
    t = 4'(mval / 10);
    o = 4'(mval % 10);
    return {t, o, mtick, mwrap};
  endfunction

  function automatic logic [9:0] dut_vec();
    return {Tens, Ones, Tick, Wrap};
  endfunction

  task automatic model_reset();
    mval = 0; mrun = 0; mtick = 0; mwrap = 0;
  endtask

  // Advance one clock: update the model with the inputs seen at the edge,
  // then return at the following falling edge where outputs are sampled.
  task automatic cycle();
    @(posedge CLOCK_50);
    if (!Resetn) begin
      model_reset();
    end else if (Load) begin
      mval  = 10 * clampd(int'(LoadVal[7:4])) + clampd(int'(LoadVal[3:0]));
      mrun  = 0; mtick = 0; mwrap = 0;
    end else if (!En) begin
      mrun = 0; mtick = 0; mwrap = 0;
    end else begin
      mrun++;
      mtick = 0; mwrap = 0;
      if (mrun == TDIV) begin
        mrun  = 0;
        mtick = 1;
        if (Up) begin
          mwrap = (mval == 99);
          mval  = (mval + 1) % 100;
        end else begin
          mwrap = (mval == 0);
          mval  = (mval + 99) % 100;
        end
      end
    end
    @(negedge CLOCK_50);
  endtask

  task automatic do_load(input logic [7:0] v);
    Load = 1'b1; LoadVal = v;
    cycle();
    Load = 1'b0;
  endtask

  task automatic test_reset();
    #2 Resetn = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (dut_vec() !== 10'h000) begin
      n_bad++;
      $display("FAIL reset_state: got %h expected %h", dut_vec(), 10'h000);
    end
    @(negedge CLOCK_50);
    cycle();
    Resetn = 1'b1;
  endtask

  task automatic test_count_up();
    En = 1'b1; Up = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      cycle();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL count_up[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if ({Tens, Ones} !== 8'h04) begin
      n_bad++;
      $display("FAIL count_up_end: got %h expected 04", {Tens, Ones});
    end
  endtask

  task automatic test_wrap_up();
    En = 1'b0;
    do_load(8'h98);
    En = 1'b1; Up = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL wrap_up[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
      end
      if (i == 8) begin
        n_cmp++;
        if (dut_vec() !== {8'h00, 2'b11}) begin
          n_bad++;
          $display("FAIL wrap_up_00: got %h expected %h", dut_vec(), {8'h00, 2'b11});
        end
      end
    end
  endtask

  task automatic test_wrap_down();
    En = 1'b0; Up = 1'b0;
    do_load(8'h10);
    En = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cycle();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL borrow[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if ({Tens, Ones} !== 8'h08) begin
      n_bad++;
      $display("FAIL borrow_08: got %h expected 08", {Tens, Ones});
    end
    do_load(8'h00);
    for (int i = 1; i <= 4; i++) begin
      cycle();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL wrap_down[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (dut_vec() !== {8'h99, 2'b11}) begin
      n_bad++;
      $display("FAIL wrap_down_99: got %h expected %h", dut_vec(), {8'h99, 2'b11});
    end
  endtask

  task automatic test_clamp_priority();
    En = 1'b0; Up = 1'b1;
    do_load(8'h20);
    En = 1'b1;
    repeat (3) cycle();
    // Divider now at zero: this load collides with a pending step.
    Load = 1'b1; LoadVal = 8'hAF;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      n_cmp++;
      if (dut_vec() !== {8'h99, 2'b00} || dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL clamp_hold[%0d]: got %h expected %h", i, dut_vec(), {8'h99, 2'b00});
      end
    end
    Load = 1'b0;
  endtask

  task automatic test_pause_resume();
    En = 1'b0; Up = 1'b1;
    do_load(8'h42);
    En = 1'b1;
    repeat (2) cycle();
    En = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      cycle();
      n_cmp++;
      if (dut_vec() !== {8'h42, 2'b00} || dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL pause[%0d]: got %h expected %h", i, dut_vec(), {8'h42, 2'b00});
      end
    end
    En = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cycle();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL resume[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (dut_vec() !== {8'h43, 2'b10}) begin
      n_bad++;
      $display("FAIL resume_43: got %h expected %h", dut_vec(), {8'h43, 2'b10});
    end
  endtask

  task automatic test_async_reset();
    En = 1'b0; Up = 1'b1;
    do_load(8'h57);
    En = 1'b1;
    repeat (2) cycle();
    #2 Resetn = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (dut_vec() !== 10'h000) begin
      n_bad++;
      $display("FAIL async_reset: got %h expected %h", dut_vec(), 10'h000);
    end
    @(negedge CLOCK_50);
    Resetn = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cycle();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL post_reset[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (dut_vec() !== {8'h01, 2'b10}) begin
      n_bad++;
      $display("FAIL post_reset_01: got %h expected %h", dut_vec(), {8'h01, 2'b10});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      En      = ($urandom_range(0, 9) != 0);
      Up      = ($urandom_range(0, 15) != 0) ? Up : ~Up;
      Load    = ($urandom_range(0, 29) == 0);
      LoadVal = 8'($urandom);
      cycle();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL random[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
    Load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap_up();
    test_wrap_down();
    test_clamp_priority();
    test_pause_resume();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
